// File: rtl/tag_assign_stage_pkg.sv
// Shared types and constants for the rename-side tag assignment stage.
package tag_assign_stage_pkg;

  localparam int unsigned NUM_ISSUE_DEF = 4;
  localparam int unsigned TAG_LEN_DEF   = 7;

  typedef logic [TAG_LEN_DEF-1:0] Tag;
  typedef logic [TAG_LEN_DEF-2:0] RFTag;

  // MSB set selects the immediate/no-register space.
  localparam Tag TAG_NONE = {1'b1, {(TAG_LEN_DEF-1){1'b0}}};

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  function automatic int unsigned popcount(input logic [31:0] m);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) n += int'(m[i]);
    return n;
  endfunction

endpackage

// File: rtl/tag_assign_stage_if.sv
// Tag-buffer issue-slot bundle: offered-valid mask, demand mask and pop mask.
interface tag_assign_stage_if #(
  parameter int unsigned NUM_ISSUE = 4
);
  logic [NUM_ISSUE-1:0] tagsValid;
  logic [NUM_ISSUE-1:0] needMask;
  logic [NUM_ISSUE-1:0] useMask;

  modport master (output tagsValid, output needMask, input useMask);
  modport slave  (input tagsValid, input needMask, output useMask);
endinterface

// File: rtl/tag_compact_select.sv
// Compacting selector: maps the k-th needing slot onto the k-th valid offered tag.
module tag_compact_select
  import tag_assign_stage_pkg::*;
#(
  parameter int unsigned NUM_ISSUE = 4,
  parameter int unsigned IDXW      = 2
) (
  tag_assign_stage_if.slave                 sel,
  output logic [NUM_ISSUE-1:0][IDXW-1:0]    o_srcIdx,
  output logic                              o_enough
);
  localparam int unsigned CW = IDXW + 1;

  logic [NUM_ISSUE-1:0][CW-1:0] w_rankV;
  logic [NUM_ISSUE-1:0][CW-1:0] w_rankN;
  logic [CW-1:0]                w_need;
  logic [CW-1:0]                w_have;

  always_comb begin
    w_need   = CW'(popcount(32'(sel.needMask)));
    w_have   = CW'(popcount(32'(sel.tagsValid)));
    o_enough = (w_need <= w_have);

    // Exclusive prefix counts give each slot its rank within its own mask.
    w_rankV = '0;
    w_rankN = '0;
    for (int unsigned i = 1; i < NUM_ISSUE; i++) begin
      w_rankV[i] = w_rankV[i-1] + CW'(sel.tagsValid[i-1]);
      w_rankN[i] = w_rankN[i-1] + CW'(sel.needMask[i-1]);
    end

    sel.useMask = '0;
    o_srcIdx    = '0;
    for (int unsigned i = 0; i < NUM_ISSUE; i++) begin
      sel.useMask[i] = sel.tagsValid[i] && (w_rankV[i] < w_need);
      for (int unsigned j = 0; j < NUM_ISSUE; j++) begin
        if (sel.needMask[i] && sel.tagsValid[j] && (w_rankV[j] == w_rankN[i]))
          o_srcIdx[i] = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/tag_assign_stage.sv
// Binds free physical tags to a decoded group and registers it for the rename stage.
module tag_assign_stage
  import tag_assign_stage_pkg::*;
#(
  parameter int unsigned NUM_ISSUE = NUM_ISSUE_DEF,
  parameter int unsigned TAG_LEN   = TAG_LEN_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 IN_mispr,
  input  logic                                 IN_mispredFlush,
  input  logic [NUM_ISSUE-1:0]                 IN_instValid,
  input  logic [NUM_ISSUE-1:0]                 IN_needTag,
  output logic                                 OUT_stall,
  input  logic [NUM_ISSUE-1:0][TAG_LEN-2:0]    IN_tags,
  input  logic [NUM_ISSUE-1:0]                 IN_tagsValid,
  output logic [NUM_ISSUE-1:0]                 OUT_tagUse,
  input  logic                                 IN_stall,
  output logic [NUM_ISSUE-1:0]                 OUT_valid,
  output logic [NUM_ISSUE-1:0][TAG_LEN-1:0]    OUT_tagDst,
  output logic [31:0]                          OUT_stallCycles
);
  localparam int unsigned IDXW = (NUM_ISSUE > 1) ? $clog2(NUM_ISSUE) : 1;
  localparam logic [TAG_LEN-1:0] W_TAG_NONE = {1'b1, {(TAG_LEN-1){1'b0}}};

  logic [0:0]                           r_state;
  logic [NUM_ISSUE-1:0]                 r_valid;
  logic [NUM_ISSUE-1:0][TAG_LEN-1:0]    r_tagDst;
  logic [31:0]                          r_stallCycles;

  logic [NUM_ISSUE-1:0]                 w_needMask;
  logic [NUM_ISSUE-1:0][IDXW-1:0]       w_srcIdx;
  logic                                 w_enough;
  logic                                 w_accept;
  logic [NUM_ISSUE-1:0][TAG_LEN-1:0]    w_tagDstNext;

  tag_assign_stage_if #(.NUM_ISSUE(NUM_ISSUE)) u_sel_if ();

  assign w_needMask         = IN_instValid & IN_needTag;
  assign u_sel_if.tagsValid = IN_tagsValid;
  assign u_sel_if.needMask  = w_needMask;

  tag_compact_select #(
    .NUM_ISSUE (NUM_ISSUE),
    .IDXW      (IDXW)
  ) u_select (
    .sel      (u_sel_if.slave),
    .o_srcIdx (w_srcIdx),
    .o_enough (w_enough)
  );

  // Gating on rst keeps the tag buffer untouched while reset is held.
  assign w_accept = rst && (r_state == ST_RUN) && !IN_mispr && !IN_mispredFlush &&
                    !IN_stall && (|IN_instValid) && w_enough;

  assign OUT_stall  = (|IN_instValid) && !w_accept;
  assign OUT_tagUse = w_accept ? u_sel_if.useMask : '0;

  always_comb begin
    w_tagDstNext = '0;
    for (int unsigned i = 0; i < NUM_ISSUE; i++)
      w_tagDstNext[i] = w_needMask[i] ? {1'b0, IN_tags[w_srcIdx[i]]} : W_TAG_NONE;
  end

  // The flush exit cycle is still FLUSH, which produces the one-cycle bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= ST_RUN;
    else if (IN_mispr)
      r_state <= ST_FLUSH;
    else if ((r_state == ST_FLUSH) && !IN_mispredFlush)
      r_state <= ST_RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid  <= '0;
      r_tagDst <= '0;
    end else if (IN_mispr) begin
      r_valid <= '0;
    end else if (w_accept) begin
      r_valid  <= IN_instValid;
      r_tagDst <= w_tagDstNext;
    end else if (!IN_stall) begin
      r_valid <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_stallCycles <= '0;
    else if (OUT_stall && (r_stallCycles != '1))
      r_stallCycles <= r_stallCycles + 32'd1;
  end

  assign OUT_valid       = r_valid;
  assign OUT_tagDst      = r_tagDst;
  assign OUT_stallCycles = r_stallCycles;

endmodule

// File: tb/tb_tag_assign_stage.sv
// Directed scoreboard bench for tag_assign_stage.
module tb_tag_assign_stage;
  import tag_assign_stage_pkg::*;

  typedef struct packed {
    logic [3:0]      v;
    logic [3:0][6:0] dst;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            IN_mispr;
  logic            IN_mispredFlush;
  logic [3:0]      IN_instValid;
  logic            OUT_stall;
  logic [3:0][5:0] IN_tags;
  logic            IN_stall;
  logic [3:0]      OUT_valid;
  logic [3:0][6:0] OUT_tagDst;
  logic [31:0]     OUT_stallCycles;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        sb[$];

  tag_assign_stage_if #(.NUM_ISSUE(4)) tif ();

  tag_assign_stage #(
    .NUM_ISSUE (4),
    .TAG_LEN   (7)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .IN_mispr        (IN_mispr),
    .IN_mispredFlush (IN_mispredFlush),
    .IN_instValid    (IN_instValid),
    .IN_needTag      (tif.needMask),
    .OUT_stall       (OUT_stall),
    .IN_tags         (IN_tags),
    .IN_tagsValid    (tif.tagsValid),
    .OUT_tagUse      (tif.useMask),
    .IN_stall        (IN_stall),
    .OUT_valid       (OUT_valid),
    .OUT_tagDst      (OUT_tagDst),
    .OUT_stallCycles (OUT_stallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] iv, input logic [3:0] nt, input logic [3:0] tv,
                       input logic [3:0][5:0] tg);
    IN_instValid  = iv;
    tif.needMask  = nt;
    tif.tagsValid = tv;
    IN_tags       = tg;
  endtask

  task automatic push_exp(input logic [3:0] v, input logic [3:0][6:0] dst);
    exp_t e;
    e.v   = v;
    e.dst = dst;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=no queued entry expected=queued entry", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_valid"}, 64'(OUT_valid), 64'(e.v));
      chk({name, "_dst"}, 64'(OUT_tagDst), 64'(e.dst));
    end
  endtask

  initial begin
    rst = 1'b0;
    IN_mispr = 1'b0;
    IN_mispredFlush = 1'b0;
    IN_stall = 1'b0;
    drive(4'b1111, 4'b1111, 4'b1111, {6'd3, 6'd2, 6'd1, 6'd0});
    #1;
    chk("rst_valid", 64'(OUT_valid), 64'h0);
    chk("rst_dst", 64'(OUT_tagDst), 64'h0);
    chk("rst_cnt", 64'(OUT_stallCycles), 64'h0);
    chk("rst_use", 64'(tif.useMask), 64'h0);

    // All four tags offered, all four slots need one.
    @(negedge clk);
    rst = 1'b1;
    drive(4'b1111, 4'b1111, 4'b1111, {6'd13, 6'd12, 6'd11, 6'd10});
    #1;
    chk("t1_use", 64'(tif.useMask), 64'hF);
    chk("t1_stall", 64'(OUT_stall), 64'h0);
    push_exp(4'b1111, {7'd13, 7'd12, 7'd11, 7'd10});
    @(posedge clk); #1;
    pop_check("t1");

    // Sparse need and sparse offered tags.
    @(negedge clk);
    drive(4'b1111, 4'b1010, 4'b0110, {6'd23, 6'd22, 6'd21, 6'd20});
    #1;
    chk("t2_use", 64'(tif.useMask), 64'h6);
    chk("t2_stall", 64'(OUT_stall), 64'h0);
    push_exp(4'b1111, {7'd22, TAG_NONE, 7'd21, TAG_NONE});
    @(posedge clk); #1;
    pop_check("t2");

    // Shortage: need 3, have 2.
    @(negedge clk);
    drive(4'b0111, 4'b0111, 4'b0011, {6'd33, 6'd32, 6'd31, 6'd30});
    #1;
    chk("t3_stall", 64'(OUT_stall), 64'h1);
    chk("t3_use", 64'(tif.useMask), 64'h0);
    @(posedge clk); #1;
    chk("t3_valid", 64'(OUT_valid), 64'h0);
    chk("t3_dst_hold", 64'(OUT_tagDst), 64'({7'd22, TAG_NONE, 7'd21, TAG_NONE}));
    chk("t3_cnt1", 64'(OUT_stallCycles), 64'd1);
    @(negedge clk); #1;
    chk("t3_stall2", 64'(OUT_stall), 64'h1);
    @(posedge clk); #1;
    chk("t3_cnt2", 64'(OUT_stallCycles), 64'd2);
    @(negedge clk);
    tif.tagsValid = 4'b1011;
    #1;
    chk("t3_use_ok", 64'(tif.useMask), 64'hB);
    chk("t3_stall_ok", 64'(OUT_stall), 64'h0);
    push_exp(4'b0111, {TAG_NONE, 7'd33, 7'd31, 7'd30});
    @(posedge clk); #1;
    pop_check("t3");
    chk("t3_cnt_hold", 64'(OUT_stallCycles), 64'd2);

    // Mispredict overrides IN_stall, then three flush cycles and a bubble.
    @(negedge clk);
    drive(4'b1111, 4'b1111, 4'b1111, {6'd43, 6'd42, 6'd41, 6'd40});
    IN_mispr = 1'b1;
    IN_stall = 1'b1;
    #1;
    chk("t4_use", 64'(tif.useMask), 64'h0);
    chk("t4_stall", 64'(OUT_stall), 64'h1);
    @(posedge clk); #1;
    chk("t4_valid_clr", 64'(OUT_valid), 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      IN_mispr = 1'b0;
      IN_stall = 1'b0;
      IN_mispredFlush = 1'b1;
      #1;
      chk("flush_stall", 64'(OUT_stall), 64'h1);
      chk("flush_use", 64'(tif.useMask), 64'h0);
    end
    @(negedge clk);
    IN_mispredFlush = 1'b0;
    #1;
    chk("bubble_stall", 64'(OUT_stall), 64'h1);
    chk("bubble_use", 64'(tif.useMask), 64'h0);
    @(negedge clk); #1;
    chk("t4_stall_ok", 64'(OUT_stall), 64'h0);
    chk("t4_use_ok", 64'(tif.useMask), 64'hF);
    push_exp(4'b1111, {7'd43, 7'd42, 7'd41, 7'd40});
    @(posedge clk); #1;
    pop_check("t4");
    chk("t4_cnt", 64'(OUT_stallCycles), 64'd7);

    // Downstream stall holds the registered group.
    @(negedge clk);
    drive(4'b1111, 4'b0001, 4'b1111, {6'd53, 6'd52, 6'd51, 6'd50});
    IN_stall = 1'b1;
    #1;
    chk("t5_use", 64'(tif.useMask), 64'h0);
    chk("t5_stall", 64'(OUT_stall), 64'h1);
    @(posedge clk); #1;
    chk("t5_valid_hold", 64'(OUT_valid), 64'hF);
    chk("t5_dst_hold", 64'(OUT_tagDst), 64'({7'd43, 7'd42, 7'd41, 7'd40}));
    chk("t5_cnt", 64'(OUT_stallCycles), 64'd8);
    @(negedge clk);
    IN_stall = 1'b0;
    #1;
    chk("t5_use_ok", 64'(tif.useMask), 64'h1);
    chk("t5_stall_ok", 64'(OUT_stall), 64'h0);
    push_exp(4'b1111, {TAG_NONE, TAG_NONE, TAG_NONE, 7'd50});
    @(posedge clk); #1;
    pop_check("t5");

    // need=0 is accepted with no tags offered.
    @(negedge clk);
    drive(4'b0011, 4'b0000, 4'b0000, {6'd63, 6'd62, 6'd61, 6'd60});
    #1;
    chk("t6_stall", 64'(OUT_stall), 64'h0);
    chk("t6_use", 64'(tif.useMask), 64'h0);
    push_exp(4'b0011, {TAG_NONE, TAG_NONE, TAG_NONE, TAG_NONE});
    @(posedge clk); #1;
    pop_check("t6");

    // Idle: no stall, valid drops.
    @(negedge clk);
    drive(4'b0000, 4'b0000, 4'b1111, {6'd3, 6'd2, 6'd1, 6'd0});
    #1;
    chk("t7_stall", 64'(OUT_stall), 64'h0);
    chk("t7_use", 64'(tif.useMask), 64'h0);
    @(posedge clk); #1;
    chk("t7_valid", 64'(OUT_valid), 64'h0);

    // Asynchronous reset mid-stream.
    @(negedge clk);
    drive(4'b1111, 4'b1111, 4'b1111, {6'd7, 6'd6, 6'd5, 6'd4});
    push_exp(4'b1111, {7'd7, 7'd6, 7'd5, 7'd4});
    @(posedge clk); #1;
    pop_check("t8");
    #1;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(OUT_valid), 64'h0);
    chk("arst_dst", 64'(OUT_tagDst), 64'h0);
    chk("arst_cnt", 64'(OUT_stallCycles), 64'h0);

    // Counter saturation from a preloaded value.
    @(negedge clk);
    rst = 1'b1;
    drive(4'b0001, 4'b0001, 4'b0000, {6'd3, 6'd2, 6'd1, 6'd0});
    force dut.r_stallCycles = 32'hFFFF_FFFE;
    #1;
    release dut.r_stallCycles;
    chk("sat_stall", 64'(OUT_stall), 64'h1);
    @(posedge clk); #1;
    chk("sat_cnt1", 64'(OUT_stallCycles), 64'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    #1;
    chk("sat_cnt3", 64'(OUT_stallCycles), 64'hFFFF_FFFF);

    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
